// File: rtl/ps2_sequencer.sv
// ps2 bus master: polls status, drains received bytes into a small FIFO,
// re-arms reception after each byte and forwards host-to-device command bytes.
module ps2_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int POLL_INTERVAL = 16,
    parameter int TIMEOUT       = 255,
    parameter int WE_PULSE      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_pop,
    output logic [7:0]                    rx_data,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    input  logic                          cmd_valid,
    input  logic [7:0]                    cmd_data,
    output logic                          cmd_ready,
    output logic [7:0]                    parity_errs,
    output logic                          timeout_err,
    output logic                          ps2_n_sel,
    output logic                          ps2_a,
    output logic                          ps2_n_oe,
    output logic                          ps2_n_we,
    output logic [7:0]                    ps2_d_out,
    output logic                          ps2_d_oe,
    input  logic [7:0]                    ps2_d_in,
    input  logic                          ps2_rdy
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int TW  = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int WTW = $clog2(TIMEOUT + 1);
    localparam int PW  = $clog2(WE_PULSE + 1);

    localparam logic [TW-1:0]  POLL_LAST = TW'(POLL_INTERVAL - 1);
    localparam logic [WTW-1:0] WAIT_LAST = WTW'(TIMEOUT - 1);
    localparam logic [PW-1:0]  WE_LAST   = PW'(WE_PULSE - 1);
    localparam logic [CW-1:0]  FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        IDLE,
        S_SETUP,
        S_WAIT,
        D_SETUP,
        D_WAIT,
        ACK_SETUP,
        ACK_WE,
        CMD_SETUP,
        CMD_WE,
        HOLD
    } state_t;

    state_t          state;
    logic [TW-1:0]   poll_tmr;
    logic [WTW-1:0]  wait_cnt;
    logic [PW-1:0]   we_cnt;
    logic            par_flag;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_full;
    logic            push;
    logic            pop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign fifo_full = (fifo_cnt == FULL_CNT);
    assign rx_empty  = (fifo_cnt == '0);
    assign rx_count  = fifo_cnt;
    assign rx_data   = fifo_mem[rd_ptr];

    // A byte is taken only on the rdy edge of a data read whose status was clean.
    assign push = !rst && (state == D_WAIT) && ps2_rdy && !par_flag;
    assign pop  = rx_pop && !rx_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ps2_d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            poll_tmr    <= '0;
            wait_cnt    <= '0;
            we_cnt      <= '0;
            par_flag    <= 1'b0;
            cmd_ready   <= 1'b0;
            parity_errs <= '0;
            timeout_err <= 1'b0;
            ps2_n_sel   <= 1'b1;
            ps2_a       <= 1'b0;
            ps2_n_oe    <= 1'b1;
            ps2_n_we    <= 1'b1;
            ps2_d_out   <= '0;
            ps2_d_oe    <= 1'b0;
        end else begin
            cmd_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (poll_tmr == POLL_LAST || cmd_valid) begin
                        state     <= S_SETUP;
                        ps2_n_sel <= 1'b0;
                        ps2_a     <= 1'b1;
                    end else begin
                        poll_tmr <= poll_tmr + TW'(1);
                    end
                end

                S_SETUP: begin
                    state    <= S_WAIT;
                    ps2_n_oe <= 1'b0;
                    wait_cnt <= '0;
                end

                S_WAIT: begin
                    if (ps2_rdy) begin
                        ps2_n_oe <= 1'b1;
                        par_flag <= ps2_d_in[1];
                        if (ps2_d_in[0] && !fifo_full) begin
                            state <= D_SETUP;
                            ps2_a <= 1'b0;
                        end else if (!ps2_d_in[0] && cmd_valid) begin
                            state     <= CMD_SETUP;
                            ps2_a     <= 1'b0;
                            ps2_d_out <= cmd_data;
                            ps2_d_oe  <= 1'b1;
                        end else begin
                            // Full FIFO leaves the byte unacknowledged in the ps2 so
                            // the device stays inhibited until a later poll.
                            state     <= IDLE;
                            ps2_n_sel <= 1'b1;
                            ps2_a     <= 1'b0;
                            poll_tmr  <= '0;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= IDLE;
                        ps2_n_oe    <= 1'b1;
                        ps2_n_sel   <= 1'b1;
                        ps2_a       <= 1'b0;
                        timeout_err <= 1'b1;
                        poll_tmr    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WTW'(1);
                    end
                end

                D_SETUP: begin
                    state    <= D_WAIT;
                    ps2_n_oe <= 1'b0;
                    wait_cnt <= '0;
                end

                D_WAIT: begin
                    if (ps2_rdy) begin
                        ps2_n_oe <= 1'b1;
                        if (par_flag) begin
                            parity_errs <= sat_inc8(parity_errs);
                        end
                        state     <= ACK_SETUP;
                        ps2_a     <= 1'b1;
                        ps2_d_out <= 8'h00;
                        ps2_d_oe  <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= IDLE;
                        ps2_n_oe    <= 1'b1;
                        ps2_n_sel   <= 1'b1;
                        ps2_a       <= 1'b0;
                        timeout_err <= 1'b1;
                        poll_tmr    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WTW'(1);
                    end
                end

                ACK_SETUP, CMD_SETUP: begin
                    state    <= (state == ACK_SETUP) ? ACK_WE : CMD_WE;
                    ps2_n_we <= 1'b0;
                    we_cnt   <= '0;
                end

                ACK_WE, CMD_WE: begin
                    if (we_cnt == WE_LAST) begin
                        ps2_n_we <= 1'b1;
                        state    <= HOLD;
                        if (state == CMD_WE) begin
                            cmd_ready <= 1'b1;
                        end
                    end else begin
                        we_cnt <= we_cnt + PW'(1);
                    end
                end

                HOLD: begin
                    state     <= IDLE;
                    ps2_n_sel <= 1'b1;
                    ps2_d_oe  <= 1'b0;
                    ps2_a     <= 1'b0;
                    poll_tmr  <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_sequencer.sv
// Bench for ps2_sequencer: behavioural ps2 device, directed table, corner
// sequences and a randomized scoreboard run.
module tb_ps2_sequencer;

    localparam int FIFO_DEPTH    = 4;
    localparam int POLL_INTERVAL = 16;
    localparam int TIMEOUT       = 255;
    localparam int WE_PULSE      = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_pop = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic [2:0] rx_count;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic [7:0] parity_errs;
    logic       timeout_err;
    logic       ps2_n_sel, ps2_a, ps2_n_oe, ps2_n_we, ps2_d_oe;
    logic [7:0] ps2_d_out;
    logic [7:0] ps2_d_in = 8'h00;
    logic       ps2_rdy = 1'b0;

    ps2_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH), .POLL_INTERVAL(POLL_INTERVAL),
        .TIMEOUT(TIMEOUT), .WE_PULSE(WE_PULSE)
    ) dut (
        .clk(clk), .rst(rst), .rx_pop(rx_pop), .rx_data(rx_data),
        .rx_empty(rx_empty), .rx_count(rx_count), .cmd_valid(cmd_valid),
        .cmd_data(cmd_data), .cmd_ready(cmd_ready), .parity_errs(parity_errs),
        .timeout_err(timeout_err), .ps2_n_sel(ps2_n_sel), .ps2_a(ps2_a),
        .ps2_n_oe(ps2_n_oe), .ps2_n_we(ps2_n_we), .ps2_d_out(ps2_d_out),
        .ps2_d_oe(ps2_d_oe), .ps2_d_in(ps2_d_in), .ps2_rdy(ps2_rdy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural ps2 device ----------------
    typedef struct { logic [7:0] d; bit par; } dev_byte_t;
    dev_byte_t dev_q[$];
    int dev_lat_max = 0;
    bit stall_all = 0;
    bit stall_data = 0;
    int lat_cnt = 0;
    int data_reads = 0;
    int status_reads = 0;

    always @(negedge clk) begin
        logic [5:0] junk;
        logic       avail, par;
        if (!ps2_n_oe && !ps2_n_sel) begin
            if (ps2_rdy || stall_all || (stall_data && !ps2_a)) begin
                // hold current response
            end else if (lat_cnt > 0) begin
                lat_cnt--;
            end else begin
                ps2_rdy = 1'b1;
                if (ps2_a) begin
                    status_reads++;
                    junk  = 6'($urandom);
                    avail = (dev_q.size() != 0);
                    par   = avail ? dev_q[0].par : 1'b0;
                    ps2_d_in = {junk, par, avail};
                end else begin
                    data_reads++;
                    if (dev_q.size() != 0) begin
                        ps2_d_in = dev_q[0].d;
                        void'(dev_q.pop_front());
                    end else begin
                        ps2_d_in = 8'($urandom);
                    end
                end
            end
        end else begin
            ps2_rdy  = 1'b0;
            ps2_d_in = 8'($urandom);
            lat_cnt  = $urandom_range(dev_lat_max, 0);
        end
    end

    // ---------------- bus monitor ----------------
    typedef struct { bit a; logic [7:0] d; int width; } wr_t;
    wr_t wr_log[$];
    bit  prev_we = 1'b1;
    int  inv_viol = 0;
    int  oe_run = 0;
    int  last_oe_run = 0;
    int  ack_cnt = 0;
    int  cmd_wr_cnt = 0;
    int  cmd_ready_cnt = 0;

    always @(negedge clk) begin
        if (!ps2_n_we) begin
            if (prev_we) begin
                wr_log.push_back('{a: ps2_a, d: ps2_d_out, width: 1});
                if (ps2_a) ack_cnt++; else cmd_wr_cnt++;
            end else begin
                wr_log[wr_log.size()-1].width++;
            end
            if (!ps2_d_oe) inv_viol++;
        end else if (!prev_we && wr_log[wr_log.size()-1].width != WE_PULSE) begin
            inv_viol++;
        end
        prev_we = ps2_n_we;
        if (!ps2_n_oe && !ps2_n_we) inv_viol++;
        if ((!ps2_n_oe || !ps2_n_we) && ps2_n_sel) inv_viol++;
        if (!ps2_n_oe) begin
            oe_run++;
        end else begin
            if (oe_run != 0) last_oe_run = oe_run;
            oe_run = 0;
        end
        if (cmd_ready) cmd_ready_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_acks(input int target, input string name);
        int n = 0;
        while (!(ack_cnt >= target && ps2_n_sel) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check({name, "_ack_wait"}, 32'(ack_cnt), 32'(target));
    endtask

    task automatic pop_expect(input logic [7:0] exp, input string name);
        check(name, {23'd0, rx_empty, rx_data}, {23'd0, 1'b0, exp});
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] b, input string name);
        int n = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 2000) begin
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        if (n >= 2000) check({name, "_ready_wait"}, 32'(cmd_ready), 32'd1);
        tick();
    endtask

    typedef struct { bit par; logic [7:0] d; int exp_cnt; logic [7:0] exp_head; int exp_perr; } vec_t;
    vec_t tbl[5];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, ak0, dr0, sr0, cr0, cw0, wl0, ci, nbad, cyc;
        logic [7:0] cmds[4];
        logic [7:0] exp_q[$];
        logic [7:0] got[$];
        int acks_seen;
        int cmd_idx;

        tbl[0] = '{par: 1'b0, d: 8'hA5, exp_cnt: 1, exp_head: 8'hA5, exp_perr: 0};
        tbl[1] = '{par: 1'b1, d: 8'h84, exp_cnt: 1, exp_head: 8'hA5, exp_perr: 1};
        tbl[2] = '{par: 1'b0, d: 8'h02, exp_cnt: 2, exp_head: 8'hA5, exp_perr: 1};
        tbl[3] = '{par: 1'b0, d: 8'hFF, exp_cnt: 3, exp_head: 8'hA5, exp_perr: 1};
        tbl[4] = '{par: 1'b0, d: 8'h00, exp_cnt: 4, exp_head: 8'hA5, exp_perr: 1};

        // ---- reset and first poll ----
        rst = 1'b1;
        repeat (3) tick();
        check("reset_bus", {ps2_n_sel, ps2_a, ps2_n_oe, ps2_n_we, ps2_d_oe, ps2_d_out},
              {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
        check("reset_fifo", {rx_empty, rx_count}, {1'b1, 3'd0});
        check("reset_status", {cmd_ready, timeout_err, parity_errs}, 10'd0);
        rst = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (!ps2_n_sel) break;
        end
        check("first_poll_delay", 32'(n), 32'(POLL_INTERVAL));
        check("first_poll_a", 32'(ps2_a), 32'd1);
        tick();

        // ---- directed receive table ----
        for (int i = 0; i < 5; i++) begin
            ak0 = ack_cnt;
            dev_q.push_back('{d: tbl[i].d, par: tbl[i].par});
            wait_acks(ak0 + 1, "tbl");
            check($sformatf("tbl%0d_count", i), 32'(rx_count), 32'(tbl[i].exp_cnt));
            check($sformatf("tbl%0d_head", i), 32'(rx_data), 32'(tbl[i].exp_head));
            check($sformatf("tbl%0d_perr", i), 32'(parity_errs), 32'(tbl[i].exp_perr));
            check($sformatf("tbl%0d_ack", i), {wr_log[wr_log.size()-1].a, 8'(wr_log[wr_log.size()-1].width)},
                  {1'b1, 8'(WE_PULSE)});
        end

        // ---- FIFO full: byte stays in the device until a slot frees ----
        dev_q.push_back('{d: 8'h5A, par: 1'b0});
        ak0 = ack_cnt; dr0 = data_reads; sr0 = status_reads;
        repeat (3 * POLL_INTERVAL + 30) tick();
        check("full_no_data_read", 32'(data_reads), 32'(dr0));
        check("full_no_ack", 32'(ack_cnt), 32'(ak0));
        check("full_polls_continue", 32'(status_reads > sr0 + 1), 32'd1);
        check("full_count", 32'(rx_count), 32'd4);
        pop_expect(8'hA5, "full_pop0");
        wait_acks(ak0 + 1, "full_retry");
        check("full_refill_count", 32'(rx_count), 32'd4);
        pop_expect(8'h02, "drain0");
        pop_expect(8'hFF, "drain1");
        pop_expect(8'h00, "drain2");
        pop_expect(8'h5A, "drain3");
        check("drain_empty", {rx_empty, rx_count}, {1'b1, 3'd0});
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        check("pop_on_empty", {rx_empty, rx_count}, {1'b1, 3'd0});

        // ---- command write, idle device ----
        cr0 = cmd_ready_cnt; cw0 = cmd_wr_cnt;
        send_cmd(8'hFF, "cmd_ff");
        repeat (4) tick();
        check("cmd_ff_ready_pulses", 32'(cmd_ready_cnt - cr0), 32'd1);
        check("cmd_ff_writes", 32'(cmd_wr_cnt - cw0), 32'd1);
        check("cmd_ff_bus", {wr_log[wr_log.size()-1].a, wr_log[wr_log.size()-1].d}, {1'b0, 8'hFF});

        // ---- command while a byte is pending: byte first ----
        dev_q.push_back('{d: 8'h3C, par: 1'b0});
        ak0 = ack_cnt; cr0 = cmd_ready_cnt;
        send_cmd(8'h81, "cmd_81");
        check("cmd_81_ack_first", 32'(ack_cnt - ak0), 32'd1);
        check("cmd_81_order", {wr_log[wr_log.size()-2].a, wr_log[wr_log.size()-1].a,
              wr_log[wr_log.size()-1].d}, {1'b1, 1'b0, 8'h81});
        check("cmd_81_ready_pulses", 32'(cmd_ready_cnt - cr0), 32'd1);
        pop_expect(8'h3C, "cmd_81_rx");

        // ---- timeout ----
        stall_all = 1'b1;
        n = 0;
        while (!timeout_err && n < 2000) begin
            tick();
            n++;
        end
        check("timeout_flag", 32'(timeout_err), 32'd1);
        check("timeout_oe_width", 32'(last_oe_run), 32'(TIMEOUT));
        check("timeout_released", {ps2_n_oe, ps2_n_sel}, 2'b11);
        stall_all = 1'b0;
        ak0 = ack_cnt;
        dev_q.push_back('{d: 8'h77, par: 1'b0});
        wait_acks(ak0 + 1, "after_timeout");
        pop_expect(8'h77, "after_timeout_rx");
        check("timeout_sticky", 32'(timeout_err), 32'd1);

        // ---- reset in the middle of a data read ----
        stall_data = 1'b1;
        dev_q.push_back('{d: 8'h11, par: 1'b0});
        n = 0;
        while (!(!ps2_n_oe && !ps2_a) && n < 2000) begin
            tick();
            n++;
        end
        check("dwait_reached", {ps2_n_oe, ps2_a}, 2'b00);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_bus", {ps2_n_sel, ps2_n_oe, ps2_n_we, ps2_d_oe}, 4'b1110);
        check("midreset_fifo", {rx_empty, rx_count}, {1'b1, 3'd0});
        check("midreset_status", {timeout_err, parity_errs}, 9'd0);
        stall_data = 1'b0;
        dev_q.delete();

        // ---- randomized run against scoreboard ----
        dev_lat_max = 3;
        nbad = 0;
        for (int i = 0; i < 16; i++) begin
            dev_byte_t b;
            b.d   = 8'($urandom);
            b.par = ($urandom_range(3, 0) == 0);
            dev_q.push_back(b);
            if (b.par) nbad++; else exp_q.push_back(b.d);
        end
        for (int i = 0; i < 4; i++) cmds[i] = 8'($urandom);
        wl0 = wr_log.size();
        cr0 = cmd_ready_cnt;
        ci = 0;
        cyc = 0;
        while (cyc < 20000 && !(dev_q.size() == 0 && ci == 4 && !cmd_valid &&
                                got.size() == exp_q.size() && rx_empty)) begin
            tick();
            cyc++;
            if (!rx_empty && $urandom_range(2, 0) == 0) begin
                got.push_back(rx_data);
                rx_pop = 1'b1;
            end else begin
                rx_pop = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                cmd_valid = 1'b0;
                ci++;
            end else if (!cmd_valid && ci < 4 && $urandom_range(30, 0) == 0) begin
                cmd_data  = cmds[ci];
                cmd_valid = 1'b1;
            end
        end
        rx_pop = 1'b0;
        repeat (4) tick();
        check("rand_completed", 32'(cyc < 20000), 32'd1);
        check("rand_rx_len", 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("rand_rx%0d", i), 32'(got[i]), 32'(exp_q[i]));
        check("rand_perr", 32'(parity_errs), 32'(nbad));
        acks_seen = 0;
        cmd_idx = 0;
        for (int i = wl0; i < wr_log.size(); i++) begin
            if (wr_log[i].a) begin
                acks_seen++;
            end else begin
                if (cmd_idx < 4)
                    check($sformatf("rand_cmd%0d", cmd_idx), 32'(wr_log[i].d), 32'(cmds[cmd_idx]));
                cmd_idx++;
            end
        end
        check("rand_acks", 32'(acks_seen), 32'd16);
        check("rand_cmd_writes", 32'(cmd_idx), 32'd4);
        check("rand_cmd_ready", 32'(cmd_ready_cnt - cr0), 32'd4);
        check("rand_no_timeout", 32'(timeout_err), 32'd0);
        check("bus_invariants", 32'(inv_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
